// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, oversampling and framing constants.
// The transmitter uses this package too.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_state_t;

   localparam int          OVERSAMPLE = 16;
   localparam int          DATA_BITS  = 8;
   localparam logic [3:0]  SAMPLE_LO  = 4'd7;
   localparam logic [3:0]  SAMPLE_MID = 4'd8;
   localparam logic [3:0]  SAMPLE_HI  = 4'd9;
   localparam logic [3:0]  CNT_LAST   = 4'(OVERSAMPLE - 1);
   localparam logic [2:0]  LAST_BIT   = 3'(DATA_BITS - 1);

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
// Flops reset to 1 so an idle-high line never looks like activity out of reset.
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk) begin
      if (reset) ff <= '1;
      else       ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled with 2-of-3 majority voting per bit.
// Pushes complete bytes to a FIFO; flags framing errors and FIFO overruns.
module uart_rx
   import uart_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick16,
   input  logic       rx,
   input  logic       fifo_full,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   logic rx_s;

   bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rx_s)
   );

   uart_state_t state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic [2:0]  idx, idx_n;
   logic [7:0]  shreg, shreg_n, data_n;
   logic [1:0]  smp, smp_n;
   logic        valid_n, ferr_n, ovr_n;
   logic        maj;

   // Samples from counter 7 and 8 are held; the counter-9 sample is live.
   assign maj  = maj3(smp[1], smp[0], rx_s);
   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shreg     <= '0;
         smp       <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         idx       <= idx_n;
         shreg     <= shreg_n;
         smp       <= smp_n;
         rx_data   <= data_n;
         rx_valid  <= valid_n;
         frame_err <= ferr_n;
         overrun   <= ovr_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      shreg_n = shreg;
      smp_n   = smp;
      data_n  = rx_data;
      valid_n = 1'b0;
      ferr_n  = 1'b0;
      ovr_n   = 1'b0;
      if (tick16) begin
         cnt_n = cnt + 4'd1;
         if (cnt == SAMPLE_LO)  smp_n[1] = rx_s;
         if (cnt == SAMPLE_MID) smp_n[0] = rx_s;
         case (state)
            IDLE: if (!rx_s) begin
               state_n = START;
               cnt_n   = '0;
               idx_n   = '0;
            end
            // A glitch leaves at counter 9, so reaching the wrap means a real start bit.
            START: begin
               if (cnt == SAMPLE_HI && maj) state_n = IDLE;
               else if (cnt == CNT_LAST)    state_n = DATA;
            end
            DATA: begin
               if (cnt == SAMPLE_HI) shreg_n[idx] = maj;
               if (cnt == CNT_LAST) begin
                  idx_n = idx + 3'd1;
                  if (idx == LAST_BIT) state_n = STOP;
               end
            end
            // Leaving at mid-stop lets a following start edge be caught with no idle gap.
            STOP: if (cnt == SAMPLE_HI) begin
               if (!maj) begin
                  ferr_n  = 1'b1;
                  state_n = BREAK;
               end else if (fifo_full) begin
                  ovr_n   = 1'b1;
                  state_n = IDLE;
               end else begin
                  valid_n = 1'b1;
                  data_n  = shreg;
                  state_n = IDLE;
               end
            end
            BREAK: if (rx_s) state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames driven tick-aligned, expected pulses
// queued on a scoreboard and matched by a monitor as the DUT emits them.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick16 = 1'b0;
   logic       rx = 1'b1;
   logic       fifo_full = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, overrun, busy;

   uart_rx #(.SYNC_STAGES(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .tick16    (tick16),
      .rx        (rx),
      .fifo_full (fifo_full),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         kind;   // 0 rx_valid, 1 frame_err, 2 overrun
      logic [7:0] data;
   } ev_t;

   ev_t        sb[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         tick_div = 6;
   int         tick_cnt = 0;
   int         tick_num = 0;
   logic       edge_was_tick = 1'b0;
   int         valid_tick = -1;
   int         n_valid = 0;
   logic [7:0] last_data = 8'h00;

   always @(negedge clk) begin
      if (tick_cnt >= tick_div - 1) begin
         tick16   = 1'b1;
         tick_cnt = 0;
      end else begin
         tick16   = 1'b0;
         tick_cnt = tick_cnt + 1;
      end
   end

   always @(posedge clk) begin
      edge_was_tick <= tick16;
      if (tick16) tick_num <= tick_num + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Output monitor: every pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rx_valid || frame_err || overrun) begin
         int  kind;
         ev_t e;
         kind = rx_valid ? 0 : (frame_err ? 1 : 2);
         check("pulse_exclusive", 32'(int'(rx_valid) + int'(frame_err) + int'(overrun)), 32'd1);
         check("pulse_after_tick", 32'(edge_was_tick), 32'd1);
         if (rx_valid) begin
            valid_tick = tick_num;
            n_valid++;
         end
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL unexpected_pulse: observed kind %0d data 0x%0h expected no pulse", kind, rx_data);
         end else begin
            e = sb.pop_front();
            check("pulse_kind", 32'(kind), 32'(e.kind));
            check("pulse_data", 32'(rx_data), 32'(e.data));
         end
      end
   end

   task automatic tick_wait(input int n);
      int k;
      k = n;
      while (k > 0) begin
         @(posedge clk);
         if (tick16) k--;
      end
      #1;
   endtask

   task automatic expect_ev(input int kind, input logic [7:0] d);
      ev_t e;
      e.kind = kind;
      e.data = (kind == 0) ? d : last_data;
      if (kind == 0) last_data = d;
      sb.push_back(e);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      rx = 1'b0;
      tick_wait(16);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         tick_wait(16);
      end
      rx = stop_bit;
      tick_wait(16);
   endtask

   task automatic sb_empty(input string tag);
      check(tag, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int fall_tick;
      int nv;
      #1000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int fall_tick;
      int nv;
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b0;
      check("reset_rx_data", 32'(rx_data), 32'h00);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_pulses", 32'({rx_valid, frame_err, overrun}), 32'd0);
      tick_wait(20);

      // 0x55, latency from the falling edge: detect tick + 154 ticks
      nv = n_valid;
      fall_tick = tick_num;
      expect_ev(0, 8'h55);
      send_frame(8'h55, 1'b1);
      sb_empty("sb_0x55");
      check("valid_count_0x55", 32'(n_valid - nv), 32'd1);
      check("latency_0x55", 32'(valid_tick - fall_tick), 32'd155);
      check("data_0x55", 32'(rx_data), 32'h55);
      check("busy_after_0x55", 32'(busy), 32'd0);
      tick_wait(16);

      // false start: 3 ticks low
      rx = 1'b0;
      tick_wait(3);
      rx = 1'b1;
      check("glitch_busy_high", 32'(busy), 32'd1);
      tick_wait(8);
      check("glitch_busy_low", 32'(busy), 32'd0);
      tick_wait(32);
      sb_empty("sb_glitch");
      check("glitch_data_kept", 32'(rx_data), 32'h55);

      // overrun: fifo full for the whole frame
      fifo_full = 1'b1;
      nv = n_valid;
      expect_ev(2, 8'h3C);
      send_frame(8'h3C, 1'b1);
      fifo_full = 1'b0;
      sb_empty("sb_overrun");
      check("overrun_no_valid", 32'(n_valid - nv), 32'd0);
      check("overrun_data_kept", 32'(rx_data), 32'h55);
      tick_wait(16);

      // framing error then a long break; nothing may start while low
      nv = n_valid;
      expect_ev(1, 8'hA3);
      send_frame(8'hA3, 1'b0);
      tick_wait(16 * 20);
      check("break_busy", 32'(busy), 32'd1);
      tick_wait(16 * 19);
      sb_empty("sb_break");
      check("break_no_valid", 32'(n_valid - nv), 32'd0);
      check("break_data_kept", 32'(rx_data), 32'h55);
      rx = 1'b1;
      tick_wait(16);
      check("break_exit_idle", 32'(busy), 32'd0);
      expect_ev(0, 8'h12);
      send_frame(8'h12, 1'b1);
      sb_empty("sb_0x12");
      check("data_0x12", 32'(rx_data), 32'h12);
      tick_wait(16);

      // back-to-back frames, tick every clk
      tick_div = 1;
      tick_wait(4);
      nv = n_valid;
      expect_ev(0, 8'h00);
      expect_ev(0, 8'hFF);
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      tick_wait(4);
      sb_empty("sb_b2b");
      check("b2b_valid_count", 32'(n_valid - nv), 32'd2);
      check("data_0xFF", 32'(rx_data), 32'hFF);
      tick_div = 6;
      tick_wait(16);

      // reset after the 4th data bit of 0xC7
      rx = 1'b0;
      tick_wait(16);
      for (int i = 0; i < 4; i++) begin
         rx = (8'hC7 >> i) & 8'h01;
         tick_wait(16);
      end
      tick_wait(4);
      check("pre_reset_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      rx = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      last_data = 8'h00;
      check("mid_reset_rx_data", 32'(rx_data), 32'h00);
      check("mid_reset_busy", 32'(busy), 32'd0);
      check("mid_reset_pulses", 32'({rx_valid, frame_err, overrun}), 32'd0);
      tick_wait(16);
      nv = n_valid;
      expect_ev(0, 8'h81);
      send_frame(8'h81, 1'b1);
      sb_empty("sb_0x81");
      check("valid_count_0x81", 32'(n_valid - nv), 32'd1);
      check("data_0x81", 32'(rx_data), 32'h81);
      tick_wait(8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: SYNC_STAGES, 2, number of flops in the rx input synchronizer (legal values 2..3).
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 tick16  input  1  oversample enable, one clk wide, at 16x baud rate (from the shared frequency divider).
REQ-005 rx  input  1  asynchronous serial line, idle high.
REQ-006 fifo_full  input  1  downstream RX FIFO full flag.
REQ-007 rx_data  output  8  last received byte, the FIFO data_in.
REQ-008 rx_valid  output  1  one-clk push strobe to the RX FIFO.
REQ-009 frame_err  output  1  one-clk pulse, stop bit sampled low.
REQ-010 overrun  output  1  one-clk pulse, byte dropped because fifo_full was high.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 rx SHALL pass through a SYNC_STAGES-deep synchronizer; all logic SHALL use only the synchronized value.
REQ-013 Frame format SHALL be 8N1: start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-015 IDLE: synchronized rx low SHALL move the FSM to START, clear the 4-bit tick counter and the 3-bit bit index.
REQ-016 Tick counter SHALL increment only on tick16 and SHALL wrap 15->0; clk cycles without tick16 SHALL change no state.
REQ-017 Each bit SHALL be sampled on ticks with counter 7, 8 and 9; the bit value SHALL be the 2-of-3 majority, decided on the counter-9 tick.
REQ-018 START: majority 1 SHALL count as a false start (glitch): return to IDLE with no output pulse; majority 0 SHALL move to DATA at the next counter wrap.
REQ-019 DATA: each decided bit SHALL be shifted into bit position [index]; after index 7 the FSM SHALL move to STOP at the next counter wrap.
REQ-020 STOP, majority 1, fifo_full 0: rx_data SHALL load the shifted byte and rx_valid SHALL pulse in the clk cycle after the deciding tick; FSM -> IDLE.
REQ-021 STOP, majority 1, fifo_full 1: overrun SHALL pulse instead, rx_data SHALL keep its previous value; FSM -> IDLE.
REQ-022 STOP, majority 0: frame_err SHALL pulse, no rx_valid, rx_data unchanged; FSM -> BREAK.
REQ-023 BREAK: FSM SHALL stay until synchronized rx is high, then -> IDLE; a low line SHALL never start a frame from BREAK.
REQ-024 Return to IDLE at mid-stop SHALL allow a start edge from the following frame with no idle gap.
REQ-025 fifo_full SHALL be sampled only on the stop-deciding tick.
REQ-026 rx_valid, frame_err and overrun SHALL be mutually exclusive and never wider than one clk.
REQ-027 Latency: the stop decision SHALL fall on the 154th tick16 after start detection.

Reset
REQ-028 On reset: state IDLE, counters 0, shift register 0, rx_data 0x00, rx_valid/frame_err/overrun/busy 0, synchronizer flops 1.
REQ-029 Reset mid-frame SHALL abort the frame with no pulse on any output; the next frame SHALL be received normally.

Structure
REQ-030 Package uart_pkg SHALL hold: FSM state encoding, OVERSAMPLE=16, sample ticks 7/8/9, DATA_BITS=8; the TX side shall share it.
REQ-031 The synchronizer SHALL be a separate sub-module bit_sync (parameter STAGES, reset value 1).

Verification (tick16 every 6th clk unless stated)
REQ-032 Frame 0x55, fifo_full 0 -> exactly one rx_valid, rx_data 0x55, one clk after the 154th tick after start detection; busy low afterwards.
REQ-033 rx low for 3 ticks then high -> no rx_valid/frame_err, FSM back in IDLE, busy low by the 10th tick.
REQ-034 Frame 0xA3 with stop bit 0, line then held low for 40 bit times -> one frame_err, no rx_valid, rx_data unchanged; no new frame until rx rises and then falls; next frame 0x12 received correctly.
REQ-035 rx_data 0x55, then frame 0x3C with fifo_full 1 at the stop decision -> one overrun, no rx_valid, rx_data stays 0x55.
REQ-036 Back-to-back 0x00 then 0xFF, no idle gap, tick16 every clk -> two rx_valid pulses, data 0x00 then 0xFF.
REQ-037 Reset pulsed after the 4th data bit of 0xC7, then frame 0x81 -> no pulse for 0xC7, outputs zero after reset, one rx_valid with 0x81.
